// File: rtl/game_flow_pkg.sv
// Game-loop sequencer types and default constants for game_flow_controller.
package game_flow_pkg;

    typedef logic [2:0] flow_state_t;

    localparam flow_state_t IDLE      = 3'd0;
    localparam flow_state_t SPAWN     = 3'd1;
    localparam flow_state_t FALL      = 3'd2;
    localparam flow_state_t LOCK      = 3'd3;
    localparam flow_state_t SETTLE    = 3'd4;
    localparam flow_state_t CLEAR     = 3'd5;
    localparam flow_state_t GAME_OVER = 3'd6;

    localparam int unsigned DEF_BOARD_HEIGHT       = 20;
    localparam int unsigned DEF_GRAVITY_BASE_TICKS = 8;
    localparam int unsigned DEF_LINES_PER_LEVEL    = 10;
    localparam int unsigned DEF_MAX_LEVEL          = 7;
    localparam int unsigned DEF_LINES_WIDTH        = 16;
    localparam int unsigned MAX_CLEARS_PER_LOCK    = 4;
    localparam int unsigned LEVEL_W                = 3;

endpackage

// File: rtl/tetris_pkg.sv
// Shared Tetris types: player command encodings used by the input front end and the game loop.
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_LEFT   = 3'd1,
        CMD_RIGHT  = 3'd2,
        CMD_ROTATE = 3'd3,
        CMD_DOWN   = 3'd4,
        CMD_DROP   = 3'd5
    } command_t;

endpackage

// File: rtl/gravity_timer.sv
// Counts qualified game ticks and flags the tick on which a gravity step is due.
// Period shrinks with level: max(1, BASE_TICKS - level).
module gravity_timer
    import game_flow_pkg::*;
#(
    parameter int unsigned BASE_TICKS = DEF_GRAVITY_BASE_TICKS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               clr,
    input  logic [LEVEL_W-1:0] level,
    output logic               due_c
);

    localparam int unsigned CNT_W = $clog2(BASE_TICKS + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_m1;

    // ">=" rather than "==" so a period that shrank below the count fires on the next tick
    always_comb begin
        period_m1 = '0;
        if (32'(level) < BASE_TICKS - 1) begin
            period_m1 = CNT_W'(BASE_TICKS - 1 - 32'(level));
        end
        due_c = tick & (cnt_q >= period_m1);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = due_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Tetris game-loop sequencer: spawn, gravity, moves, lock, line clear, game over,
// plus line/level bookkeeping. Emits registered one-cycle strobes to the board datapath.
module game_flow_controller
    import tetris_pkg::*;
    import game_flow_pkg::*;
#(
    parameter int unsigned BOARD_HEIGHT       = DEF_BOARD_HEIGHT,
    parameter int unsigned GRAVITY_BASE_TICKS = DEF_GRAVITY_BASE_TICKS,
    parameter int unsigned LINES_PER_LEVEL    = DEF_LINES_PER_LEVEL,
    parameter int unsigned MAX_LEVEL          = DEF_MAX_LEVEL,
    parameter int unsigned LINES_WIDTH        = DEF_LINES_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            tick,
    input  logic                            move_valid,
    input  command_t                        move,
    output logic                            move_ready,
    input  logic                            down_collision,
    input  logic                            left_collision,
    input  logic                            right_collision,
    input  logic                            rotation_collision,
    input  logic                            spawn_collision,
    input  logic                            any_full_row,
    input  logic [$clog2(BOARD_HEIGHT)-1:0] full_row_y,
    output logic                            spawn_en,
    output logic                            gravity_en,
    output logic                            left_en,
    output logic                            right_en,
    output logic                            rotate_en,
    output logic                            lock_en,
    output logic                            clear_en,
    output logic [$clog2(BOARD_HEIGHT)-1:0] clear_row,
    output logic                            game_over,
    output logic [2:0]                      level,
    output logic [LINES_WIDTH-1:0]          lines_cleared,
    output flow_state_t                     state
);

    localparam int unsigned ROW_W = $clog2(BOARD_HEIGHT);
    localparam int unsigned LIL_W = $clog2(LINES_PER_LEVEL + 1);
    localparam int unsigned CC_W  = $clog2(MAX_CLEARS_PER_LOCK + 1);

    flow_state_t            state_q, state_d;
    logic                   spawn_en_q, spawn_en_d;
    logic                   gravity_en_q, gravity_en_d;
    logic                   left_en_q, left_en_d;
    logic                   right_en_q, right_en_d;
    logic                   rotate_en_q, rotate_en_d;
    logic                   lock_en_q, lock_en_d;
    logic                   clear_en_q, clear_en_d;
    logic [ROW_W-1:0]       clear_row_q, clear_row_d;
    logic                   game_over_q, game_over_d;
    logic [LEVEL_W-1:0]     level_q, level_d;
    logic [LINES_WIDTH-1:0] lines_q, lines_d;
    logic [LIL_W-1:0]       lil_q, lil_d;
    logic [CC_W-1:0]        clear_count_q, clear_count_d;

    logic tick_c;
    logic gravity_due_c;
    logic timer_clr_c;

    // Ticks outside FALL are dropped before they reach the counter
    assign tick_c = tick & (state_q == FALL);

    gravity_timer #(
        .BASE_TICKS(GRAVITY_BASE_TICKS)
    ) u_gravity_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_c),
        .clr   (timer_clr_c),
        .level (level_q),
        .due_c (gravity_due_c)
    );

    always_comb begin
        state_d       = state_q;
        spawn_en_d    = 1'b0;
        gravity_en_d  = 1'b0;
        left_en_d     = 1'b0;
        right_en_d    = 1'b0;
        rotate_en_d   = 1'b0;
        lock_en_d     = 1'b0;
        clear_en_d    = 1'b0;
        clear_row_d   = clear_row_q;
        game_over_d   = game_over_q;
        level_d       = level_q;
        lines_d       = lines_q;
        lil_d         = lil_q;
        clear_count_d = clear_count_q;
        timer_clr_c   = 1'b0;
        move_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = SPAWN;
            end
            SPAWN: begin
                if (spawn_collision) begin
                    game_over_d = 1'b1;
                    state_d     = GAME_OVER;
                end else begin
                    spawn_en_d  = 1'b1;
                    timer_clr_c = 1'b1;
                    state_d     = FALL;
                end
            end
            FALL: begin
                // Gravity wins the cycle; a competing move stays pending
                move_ready = ~gravity_due_c;
                if (gravity_due_c) begin
                    if (down_collision) state_d = LOCK;
                    else                gravity_en_d = 1'b1;
                end
                if (move_valid & move_ready) begin
                    case (move)
                        CMD_LEFT:   left_en_d   = ~left_collision;
                        CMD_RIGHT:  right_en_d  = ~right_collision;
                        CMD_ROTATE: rotate_en_d = ~rotation_collision;
                        default:    ;
                    endcase
                end
            end
            LOCK: begin
                lock_en_d     = 1'b1;
                clear_count_d = '0;
                state_d       = SETTLE;
            end
            SETTLE: begin
                if (any_full_row && (32'(clear_count_q) < MAX_CLEARS_PER_LOCK)) state_d = CLEAR;
                else                                                          state_d = SPAWN;
            end
            CLEAR: begin
                clear_en_d    = 1'b1;
                clear_row_d   = full_row_y;
                clear_count_d = clear_count_q + CC_W'(1);
                if (lines_q != {LINES_WIDTH{1'b1}}) lines_d = lines_q + LINES_WIDTH'(1);
                if (32'(lil_q) + 32'd1 >= LINES_PER_LEVEL) begin
                    lil_d = '0;
                    if (32'(level_q) < MAX_LEVEL) level_d = level_q + LEVEL_W'(1);
                end else begin
                    lil_d = lil_q + LIL_W'(1);
                end
                state_d = SETTLE;
            end
            GAME_OVER: begin
                if (start) begin
                    lines_d       = '0;
                    level_d       = '0;
                    lil_d         = '0;
                    clear_count_d = '0;
                    game_over_d   = 1'b0;
                    timer_clr_c   = 1'b1;
                    state_d       = SPAWN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            spawn_en_q    <= 1'b0;
            gravity_en_q  <= 1'b0;
            left_en_q     <= 1'b0;
            right_en_q    <= 1'b0;
            rotate_en_q   <= 1'b0;
            lock_en_q     <= 1'b0;
            clear_en_q    <= 1'b0;
            clear_row_q   <= '0;
            game_over_q   <= 1'b0;
            level_q       <= '0;
            lines_q       <= '0;
            lil_q         <= '0;
            clear_count_q <= '0;
        end else begin
            state_q       <= state_d;
            spawn_en_q    <= spawn_en_d;
            gravity_en_q  <= gravity_en_d;
            left_en_q     <= left_en_d;
            right_en_q    <= right_en_d;
            rotate_en_q   <= rotate_en_d;
            lock_en_q     <= lock_en_d;
            clear_en_q    <= clear_en_d;
            clear_row_q   <= clear_row_d;
            game_over_q   <= game_over_d;
            level_q       <= level_d;
            lines_q       <= lines_d;
            lil_q         <= lil_d;
            clear_count_q <= clear_count_d;
        end
    end

    assign spawn_en      = spawn_en_q;
    assign gravity_en    = gravity_en_q;
    assign left_en       = left_en_q;
    assign right_en      = right_en_q;
    assign rotate_en     = rotate_en_q;
    assign lock_en       = lock_en_q;
    assign clear_en      = clear_en_q;
    assign clear_row     = clear_row_q;
    assign game_over     = game_over_q;
    assign level         = level_q;
    assign lines_cleared = lines_q;
    assign state         = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Testbench for game_flow_controller: directed scenarios plus randomized play, checked
// cycle by cycle against a behavioural model and a small board-environment model.
module tb_game_flow_controller;
    import tetris_pkg::*;
    import game_flow_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, tick, move_valid;
    command_t    move;
    logic        down_collision, left_collision, right_collision, rotation_collision;
    logic        spawn_collision, any_full_row;
    logic [4:0]  full_row_y;
    logic        move_ready, spawn_en, gravity_en, left_en, right_en, rotate_en, lock_en, clear_en;
    logic [4:0]  clear_row;
    logic        game_over;
    logic [2:0]  level;
    logic [15:0] lines_cleared;
    flow_state_t state;

    game_flow_controller #(
        .BOARD_HEIGHT(20), .GRAVITY_BASE_TICKS(8), .LINES_PER_LEVEL(10),
        .MAX_LEVEL(7), .LINES_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick),
        .move_valid(move_valid), .move(move), .move_ready(move_ready),
        .down_collision(down_collision), .left_collision(left_collision),
        .right_collision(right_collision), .rotation_collision(rotation_collision),
        .spawn_collision(spawn_collision), .any_full_row(any_full_row), .full_row_y(full_row_y),
        .spawn_en(spawn_en), .gravity_en(gravity_en), .left_en(left_en), .right_en(right_en),
        .rotate_en(rotate_en), .lock_en(lock_en), .clear_en(clear_en), .clear_row(clear_row),
        .game_over(game_over), .level(level), .lines_cleared(lines_cleared), .state(state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Behavioural model: level and period are derived from the running line total
    flow_state_t m_state = IDLE;
    int          m_ticks = 0;
    int          m_lines = 0;
    int          m_clears = 0;
    logic        m_over = 1'b0;
    logic        e_spawn, e_grav, e_left, e_right, e_rot, e_lock, e_clear;
    logic [4:0]  e_row;

    function automatic int m_level();
        int l = m_lines / 10;
        return (l > 7) ? 7 : l;
    endfunction

    function automatic int m_period();
        int p = 8 - m_level();
        return (p < 1) ? 1 : p;
    endfunction

    function automatic logic m_due();
        return tick && (m_ticks + 1 >= m_period());
    endfunction

    function automatic logic m_ready();
        return (m_state == FALL) && !m_due();
    endfunction

    function automatic void m_step();
        logic rdy, due;
        rdy = m_ready();
        due = m_due();
        {e_spawn, e_grav, e_left, e_right, e_rot, e_lock, e_clear} = '0;
        if (reset) begin
            m_state = IDLE; m_ticks = 0; m_lines = 0; m_clears = 0; m_over = 1'b0; e_row = '0;
            return;
        end
        case (m_state)
            IDLE:  if (start) m_state = SPAWN;
            SPAWN: begin
                if (spawn_collision) begin m_state = GAME_OVER; m_over = 1'b1; end
                else begin e_spawn = 1'b1; m_ticks = 0; m_state = FALL; end
            end
            FALL: begin
                if (tick) begin
                    if (due) begin
                        m_ticks = 0;
                        if (down_collision) m_state = LOCK; else e_grav = 1'b1;
                    end else m_ticks++;
                end
                if (rdy && move_valid) begin
                    if (move == CMD_LEFT)   e_left  = !left_collision;
                    if (move == CMD_RIGHT)  e_right = !right_collision;
                    if (move == CMD_ROTATE) e_rot   = !rotation_collision;
                end
            end
            LOCK:   begin e_lock = 1'b1; m_clears = 0; m_state = SETTLE; end
            SETTLE: m_state = (any_full_row && m_clears < 4) ? CLEAR : SPAWN;
            CLEAR:  begin e_clear = 1'b1; e_row = full_row_y; m_clears++; m_lines++; m_state = SETTLE; end
            GAME_OVER: if (start) begin m_lines = 0; m_ticks = 0; m_over = 1'b0; m_state = SPAWN; end
            default: m_state = IDLE;
        endcase
    endfunction

    // Board environment: full rows appear when a piece locks and vanish as they are cleared
    int rows[$];
    int plan[$];
    int ev_q[$];
    int n_grav = 0, n_spawn = 0, n_other = 0, n_move = 0;

    function automatic void env_update();
        any_full_row = (rows.size() > 0);
        full_row_y   = (rows.size() > 0) ? 5'(rows[0]) : 5'd0;
    endfunction

    task automatic idle_inputs();
        start = 0; tick = 0; move_valid = 0; move = CMD_NONE;
        down_collision = 0; left_collision = 0; right_collision = 0; rotation_collision = 0;
        spawn_collision = 0;
    endtask

    task automatic step();
        int exp_lines;
        #1;
        check_eq("move_ready", 32'(move_ready), 32'(m_ready()));
        @(posedge clk);
        m_step();
        #1;
        exp_lines = (m_lines > 65535) ? 65535 : m_lines;
        check_eq("spawn_en",   32'(spawn_en),   32'(e_spawn));
        check_eq("gravity_en", 32'(gravity_en), 32'(e_grav));
        check_eq("left_en",    32'(left_en),    32'(e_left));
        check_eq("right_en",   32'(right_en),   32'(e_right));
        check_eq("rotate_en",  32'(rotate_en),  32'(e_rot));
        check_eq("lock_en",    32'(lock_en),    32'(e_lock));
        check_eq("clear_en",   32'(clear_en),   32'(e_clear));
        if (e_clear) check_eq("clear_row", 32'(clear_row), 32'(e_row));
        check_eq("game_over",  32'(game_over),  32'(m_over));
        check_eq("level",      32'(level),      32'(m_level()));
        check_eq("lines",      32'(lines_cleared), 32'(exp_lines));
        check_eq("state",      32'(state),      32'(m_state));
        if (gravity_en) n_grav++;
        if (spawn_en) begin n_spawn++; ev_q.push_back(300); end
        if (lock_en) begin n_other++; ev_q.push_back(100); rows = plan; end
        if (clear_en) begin
            n_other++;
            ev_q.push_back(200 + int'(clear_row));
            if (rows.size() > 0) void'(rows.pop_front());
        end
        if (left_en || right_en || rotate_en) begin n_other++; n_move++; end
        env_update();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin tick = 1; step(); end
        tick = 0;
    endtask

    task automatic lock_piece(input int pre_ticks);
        ticks(pre_ticks);
        tick = 1; down_collision = 1; step();
        tick = 0; down_collision = 0;
    endtask

    task automatic run_until_spawn(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            step();
            seen = spawn_en;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic new_plan();
        int r, cnt;
        plan.delete();
        cnt = $urandom_range(0, 5);
        r = 19 - $urandom_range(0, 2);
        for (int k = 0; k < cnt; k++) begin
            plan.push_back(r);
            r -= 1 + $urandom_range(0, 1);
        end
    endtask

    initial begin
        int base, g_at;
        int exp_ev[4];
        idle_inputs();
        reset = 1;
        env_update();
        @(posedge clk);
        step();
        reset = 0;
        check_eq("rst_state", 32'(state), 32'(IDLE));
        check_eq("rst_over", 32'(game_over), 32'd0);
        check_eq("rst_lines", 32'(lines_cleared), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_row", 32'(clear_row), 32'd0);

        // Start: spawn strobe two cycles after start is sampled
        start = 1; step(); start = 0; step();
        check_eq("t1_spawn", 32'(spawn_en), 32'd1);
        check_eq("t1_state", 32'(state), 32'(FALL));
        #1 check_eq("t1_ready", 32'(move_ready), 32'd1);

        // Level 0: exactly one gravity step, on the 8th tick
        base = n_other; n_grav = 0; g_at = 0;
        for (int i = 1; i <= 8; i++) begin
            tick = 1; step();
            if (gravity_en && g_at == 0) g_at = i;
        end
        tick = 0;
        check_eq("t2_grav_count", 32'(n_grav), 32'd1);
        check_eq("t2_grav_at", 32'(g_at), 32'd8);
        check_eq("t2_other", 32'(n_other - base), 32'd0);

        // Gravity beats a same-cycle move; the move is taken next cycle
        ticks(7);
        tick = 1; move_valid = 1; move = CMD_LEFT;
        #1 check_eq("t3_ready_due", 32'(move_ready), 32'd0);
        step();
        check_eq("t3_grav", 32'(gravity_en), 32'd1);
        check_eq("t3_left_held", 32'(left_en), 32'd0);
        tick = 0; step();
        check_eq("t3_left", 32'(left_en), 32'd1);
        left_collision = 1; step();
        check_eq("t3_left_blocked", 32'(left_en), 32'd0);
        move_valid = 0; left_collision = 0; move = CMD_NONE;

        // Lock with two full rows
        plan = '{19, 18};
        ev_q.delete();
        lock_piece(7);
        run_until_spawn("t4_spawn_seen");
        exp_ev = '{100, 219, 218, 300};
        check_eq("t4_nev", 32'(ev_q.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check_eq("t4_event", 32'((k < ev_q.size()) ? ev_q[k] : -1), 32'(exp_ev[k]));
        check_eq("t4_lines", 32'(lines_cleared), 32'd2);

        // Ten single-line clears from level 0 -> level 1, period 7
        reset = 1; step(); reset = 0;
        start = 1; step(); start = 0; step();
        plan = '{19};
        for (int n = 0; n < 10; n++) begin
            lock_piece(7);
            run_until_spawn("t5_spawn_seen");
        end
        check_eq("t5_level", 32'(level), 32'd1);
        check_eq("t5_lines", 32'(lines_cleared), 32'd10);
        g_at = 0;
        for (int i = 1; i <= 7; i++) begin
            tick = 1; step();
            if (gravity_en && g_at == 0) g_at = i;
        end
        tick = 0;
        check_eq("t5_grav_at", 32'(g_at), 32'd7);

        // Spawn collision: game over, ticks and moves ignored, restart clears totals
        plan.delete();
        spawn_collision = 1;
        lock_piece(6);
        for (int i = 0; i < 5; i++) step();
        check_eq("t6_over", 32'(game_over), 32'd1);
        check_eq("t6_state", 32'(state), 32'(GAME_OVER));
        base = n_spawn;
        n_grav = 0; n_move = 0;
        move_valid = 1; move = CMD_RIGHT;
        ticks(10);
        move_valid = 0;
        check_eq("t6_no_grav", 32'(n_grav), 32'd0);
        check_eq("t6_no_move", 32'(n_move), 32'd0);
        check_eq("t6_no_spawn", 32'(n_spawn - base), 32'd0);
        spawn_collision = 0;
        start = 1; step(); start = 0; step();
        check_eq("t6_respawn", 32'(spawn_en), 32'd1);
        check_eq("t6_lines0", 32'(lines_cleared), 32'd0);
        check_eq("t6_level0", 32'(level), 32'd0);
        check_eq("t6_over0", 32'(game_over), 32'd0);

        // Randomized play, including occasional mid-sequence resets
        for (int c = 0; c < 3000; c++) begin
            reset              = ($urandom_range(0, 399) == 0);
            start              = ($urandom_range(0, 7) == 0);
            tick               = 1'($urandom_range(0, 1));
            move_valid         = 1'($urandom_range(0, 1));
            move               = command_t'(3'($urandom_range(0, 4)));
            down_collision     = ($urandom_range(0, 3) == 0);
            left_collision     = ($urandom_range(0, 2) == 0);
            right_collision    = ($urandom_range(0, 2) == 0);
            rotation_collision = ($urandom_range(0, 2) == 0);
            spawn_collision    = ($urandom_range(0, 24) == 0);
            new_plan();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
